// File: rtl/aq_djpeg_defs.sv
// Shared definitions for the JPEG DQT quantisation-table store.
// Holds the table geometry, the Pq precision codes, the parser state
// encoding and a helper that sizes the table-select field.
package aq_djpeg_defs;

    localparam int         DQT_ENTRIES  = 64;
    localparam logic [5:0] DQT_LAST_IDX = 6'(DQT_ENTRIES - 1);

    // Pq field values (upper nibble of the DQT header byte)
    localparam logic [3:0] PQ_8BIT  = 4'd0;
    localparam logic [3:0] PQ_16BIT = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_ENTRY_HI,
        ST_ENTRY_LO,
        ST_SKIP
    } dqt_state_e;

    // Width of a table-select field; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aq_djpeg_dqt_multi_if.sv
// Bus bundle between the header parser / dequantiser and the DQT store.
//   DataInStart/Enable/Last, DataIn : DQT payload byte stream (no backpressure)
//   Busy, TableValid, Error         : parser status back to the header parser
//   TableSel, TableNumber           : lookup address from the dequantiser
//   TableData                       : registered lookup result
// master = stream source / table reader, slave = the table store.
interface aq_djpeg_dqt_multi_if #(
    parameter int NUM_TABLES = 4,
    parameter int OUT_W      = 16
);
    import aq_djpeg_defs::*;

    localparam int SEL_W = sel_width(NUM_TABLES);

    logic                  DataInStart;
    logic                  DataInEnable;
    logic [7:0]            DataIn;
    logic                  DataInLast;
    logic                  Busy;
    logic [NUM_TABLES-1:0] TableValid;
    logic                  Error;
    logic [SEL_W-1:0]      TableSel;
    logic [5:0]            TableNumber;
    logic [OUT_W-1:0]      TableData;

    modport master (
        output DataInStart, DataInEnable, DataIn, DataInLast,
        output TableSel, TableNumber,
        input  Busy, TableValid, Error, TableData
    );

    modport slave (
        input  DataInStart, DataInEnable, DataIn, DataInLast,
        input  TableSel, TableNumber,
        output Busy, TableValid, Error, TableData
    );

endinterface

// File: rtl/aq_djpeg_dqt_ram.sv
// Simple dual-port table RAM for the DQT store.
//   clk, rst     : clock, async active-low reset (output register only)
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : registered read port, read-first on address collision
// The array itself is not reset.
module aq_djpeg_dqt_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Sampled in the same edge as the write, so a collision sees old data.
    always_comb begin
        rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/aq_djpeg_dqt_multi.sv
// JPEG DQT quantisation-table store.
// Parses DQT segment payload bytes (after the length field) and writes up to
// NUM_TABLES tables of 64 entries, 8- or 16-bit precision, several tables per
// segment. Entries are read back through a one-cycle-latency lookup port.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of aq_djpeg_dqt_multi_if (stream in, status, lookup)
module aq_djpeg_dqt_multi
    import aq_djpeg_defs::*;
#(
    parameter int NUM_TABLES = 4,
    parameter int OUT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    aq_djpeg_dqt_multi_if.slave    bus
);

    localparam int SEL_W  = sel_width(NUM_TABLES);
    localparam int ADDR_W = SEL_W + 6;

    dqt_state_e            state_d, state_q;
    logic [5:0]            cnt_d, cnt_q;
    logic [SEL_W-1:0]      tq_d, tq_q;
    logic                  pq16_d, pq16_q;
    logic [7:0]            hi_d, hi_q;
    logic [NUM_TABLES-1:0] valid_d, valid_q;
    logic                  err_d, err_q;
    logic                  busy_d, busy_q;

    logic                  ram_we;
    logic [15:0]           entry_word;
    logic [OUT_W-1:0]      ram_wdata;
    logic [3:0]            hdr_pq;
    logic [3:0]            hdr_tq;
    logic                  hdr_bad;

    assign hdr_pq  = bus.DataIn[7:4];
    assign hdr_tq  = bus.DataIn[3:0];
    assign hdr_bad = (hdr_pq > PQ_16BIT) || (hdr_tq >= 4'(NUM_TABLES));

    // 8-bit entries zero-extend; 16-bit entries keep the low OUT_W bits.
    assign entry_word = pq16_q ? {hi_q, bus.DataIn} : {8'h00, bus.DataIn};
    assign ram_wdata  = entry_word[OUT_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tq_d    = tq_q;
        pq16_d  = pq16_q;
        hi_d    = hi_q;
        valid_d = valid_q;
        err_d   = err_q;
        ram_we  = 1'b0;

        if (bus.DataInStart) begin
            // Abort wins over a coincident byte, which is dropped.
            state_d = ST_HEADER;
            err_d   = 1'b0;
        end else if (bus.DataInEnable) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_HEADER: begin
                    if (hdr_bad) begin
                        err_d   = 1'b1;
                        state_d = bus.DataInLast ? ST_IDLE : ST_SKIP;
                    end else begin
                        tq_d          = hdr_tq[SEL_W-1:0];
                        pq16_d        = (hdr_pq == PQ_16BIT);
                        cnt_d         = '0;
                        valid_d[hdr_tq[SEL_W-1:0]] = 1'b0;
                        if (bus.DataInLast) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = (hdr_pq == PQ_16BIT) ? ST_ENTRY_HI : ST_ENTRY_LO;
                        end
                    end
                end
                ST_ENTRY_HI: begin
                    hi_d = bus.DataIn;
                    if (bus.DataInLast) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ENTRY_LO;
                    end
                end
                ST_ENTRY_LO: begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == DQT_LAST_IDX) begin
                        valid_d[tq_q] = 1'b1;
                        state_d = bus.DataInLast ? ST_IDLE : ST_HEADER;
                    end else if (bus.DataInLast) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = pq16_q ? ST_ENTRY_HI : ST_ENTRY_LO;
                    end
                end
                ST_SKIP: begin
                    if (bus.DataInLast) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tq_q    <= '0;
            pq16_q  <= 1'b0;
            hi_q    <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tq_q    <= tq_d;
            pq16_q  <= pq16_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    aq_djpeg_dqt_ram #(
        .DEPTH  (NUM_TABLES * DQT_ENTRIES),
        .ADDR_W (ADDR_W),
        .DATA_W (OUT_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr ({tq_q, cnt_q}),
        .wdata (ram_wdata),
        .raddr ({bus.TableSel, bus.TableNumber}),
        .rdata (bus.TableData)
    );

    assign bus.Busy       = busy_q;
    assign bus.TableValid = valid_q;
    assign bus.Error      = err_q;

endmodule

// File: tb/tb_aq_djpeg_dqt_multi.sv
// Directed bench for the DQT table store: 8/16-bit loads, multi-table
// segments, bad headers, truncated tables, abort/restart and reset mid-load.
module tb_aq_djpeg_dqt_multi;

    localparam int NT = 4;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aq_djpeg_dqt_multi_if #(.NUM_TABLES(NT), .OUT_W(OW)) bus ();

    aq_djpeg_dqt_multi #(.NUM_TABLES(NT), .OUT_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic last);
        @(negedge clk);
        bus.DataInStart  = 1'b0;
        bus.DataInEnable = 1'b1;
        bus.DataIn       = b;
        bus.DataInLast   = last;
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        bus.DataInStart  = 1'b0;
        bus.DataInEnable = 1'b0;
        bus.DataInLast   = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.DataInStart  = 1'b1;
        bus.DataInEnable = 1'b0;
        bus.DataInLast   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] sel, input logic [5:0] idx,
                      input logic [31:0] exp);
        idle_cyc();
        bus.TableSel    = sel;
        bus.TableNumber = idx;
        idle_cyc();
        check_eq(tag, 32'(bus.TableData), exp);
    endtask

    initial begin
        rst              = 1'b0;
        bus.DataInStart  = 1'b0;
        bus.DataInEnable = 1'b0;
        bus.DataIn       = '0;
        bus.DataInLast   = 1'b0;
        bus.TableSel     = '0;
        bus.TableNumber  = '0;

        // Reset values
        @(negedge clk);
        check_eq("rst_busy",  32'(bus.Busy),       32'h0);
        check_eq("rst_valid", 32'(bus.TableValid), 32'h0);
        check_eq("rst_error", 32'(bus.Error),      32'h0);
        check_eq("rst_data",  32'(bus.TableData),  32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 8-bit table 1, entries 1..64
        start_pulse();
        put(8'h01, 1'b0);
        for (int i = 0; i < 64; i++) begin
            put(8'(i + 1), i == 63);
            if (i == 1) check_eq("t1_busy_mid", 32'(bus.Busy), 32'h1);
        end
        idle_cyc();
        check_eq("t1_valid", 32'(bus.TableValid), 32'h2);
        check_eq("t1_error", 32'(bus.Error),      32'h0);
        check_eq("t1_busy",  32'(bus.Busy),       32'h0);
        rd("t1_idx0",  2'd1, 6'd0,  32'h0001);
        rd("t1_idx63", 2'd1, 6'd63, 32'h0040);

        // 16-bit table 0, entries 0x0100+i, MSB first
        start_pulse();
        put(8'h10, 1'b0);
        for (int i = 0; i < 64; i++) begin
            put(8'h01, 1'b0);
            put(8'(i), i == 63);
        end
        idle_cyc();
        check_eq("t2_valid", 32'(bus.TableValid), 32'h3);
        check_eq("t2_error", 32'(bus.Error),      32'h0);
        rd("t2_idx5",  2'd0, 6'd5,  32'h0105);
        rd("t2_idx63", 2'd0, 6'd63, 32'h013F);
        rd("t2_t1_kept", 2'd1, 6'd63, 32'h0040);

        // One segment: 8-bit tables 0 (entry=i) and 3 (entry=0xFF-i)
        start_pulse();
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        check_eq("t3_valid_drop", 32'(bus.TableValid), 32'h2);
        for (int i = 1; i < 64; i++) put(8'(i), 1'b0);
        put(8'h03, 1'b0);
        check_eq("t3_valid_t0", 32'(bus.TableValid), 32'h3);
        for (int i = 0; i < 64; i++) begin
            if (i == 63) check_eq("t3_busy_before", 32'(bus.Busy), 32'h1);
            put(8'(8'hFF - i), i == 63);
        end
        idle_cyc();
        check_eq("t3_busy_after", 32'(bus.Busy),       32'h0);
        check_eq("t3_valid",      32'(bus.TableValid), 32'hB);
        check_eq("t3_error",      32'(bus.Error),      32'h0);
        rd("t3_sel3_idx0",  2'd3, 6'd0,  32'h00FF);
        rd("t3_sel3_idx63", 2'd3, 6'd63, 32'h00C0);
        rd("t3_sel0_idx7",  2'd0, 6'd7,  32'h0007);

        // Bad header 0x05: error, bytes skipped
        start_pulse();
        put(8'h05, 1'b0);
        put(8'hAA, 1'b0);
        check_eq("t4_err_rise", 32'(bus.Error), 32'h1);
        check_eq("t4_busy",     32'(bus.Busy),  32'h1);
        put(8'h00, 1'b0);
        put(8'h11, 1'b1);
        idle_cyc();
        check_eq("t4_err_stick", 32'(bus.Error),      32'h1);
        check_eq("t4_busy_end",  32'(bus.Busy),       32'h0);
        check_eq("t4_valid",     32'(bus.TableValid), 32'hB);
        start_pulse();
        idle_cyc();
        check_eq("t4_err_clr",   32'(bus.Error), 32'h0);
        check_eq("t4_busy_hdr",  32'(bus.Busy),  32'h1);

        // Truncated 8-bit table 2: last on byte 30
        put(8'h02, 1'b0);
        for (int i = 0; i < 29; i++) put(8'(i + 1), i == 28);
        idle_cyc();
        check_eq("t5_error", 32'(bus.Error),      32'h1);
        check_eq("t5_valid", 32'(bus.TableValid), 32'hB);
        check_eq("t5_busy",  32'(bus.Busy),       32'h0);

        // Partial reload of table 1, then abort with a start+enable collision
        start_pulse();
        put(8'h01, 1'b0);
        for (int i = 0; i < 10; i++) put(8'hEE, 1'b0);
        idle_cyc();
        check_eq("t5_partial_valid", 32'(bus.TableValid), 32'h9);
        @(negedge clk);
        bus.DataInStart  = 1'b1;
        bus.DataInEnable = 1'b1;
        bus.DataIn       = 8'h25;
        bus.DataInLast   = 1'b0;
        put(8'h01, 1'b0);
        for (int i = 0; i < 64; i++) put(8'(i * 3), i == 63);
        idle_cyc();
        check_eq("t5_rec_error", 32'(bus.Error),      32'h0);
        check_eq("t5_rec_valid", 32'(bus.TableValid), 32'hB);
        rd("t5_sel1_idx5",   2'd1, 6'd5,  32'h000F);
        rd("t5_sel1_idx63",  2'd1, 6'd63, 32'h00BD);
        rd("t5_sel2_idx0",   2'd2, 6'd0,  32'h0001);
        rd("t5_sel2_idx28",  2'd2, 6'd28, 32'h001D);

        // Reset during 16-bit entry 40 of table 0
        start_pulse();
        put(8'h10, 1'b0);
        for (int i = 0; i < 39; i++) begin
            put(8'h01, 1'b0);
            put(8'(i), 1'b0);
        end
        put(8'h01, 1'b0);
        check_eq("t6_valid_pre", 32'(bus.TableValid), 32'hA);
        @(negedge clk);
        bus.DataInEnable = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_busy",  32'(bus.Busy),       32'h0);
        check_eq("t6_rst_valid", 32'(bus.TableValid), 32'h0);
        check_eq("t6_rst_error", 32'(bus.Error),      32'h0);
        check_eq("t6_rst_data",  32'(bus.TableData),  32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Full reload of table 3 (entry = 0x55^i); watch idx9 for read-first
        bus.TableSel    = 2'd3;
        bus.TableNumber = 6'd9;
        start_pulse();
        put(8'h03, 1'b0);
        for (int i = 0; i < 64; i++) begin
            put(8'(8'h55 ^ i), i == 63);
            if (i == 9) begin
                idle_cyc();
                check_eq("t6_read_first", 32'(bus.TableData), 32'h00F6);
                idle_cyc();
                check_eq("t6_read_new",   32'(bus.TableData), 32'h005C);
            end
        end
        idle_cyc();
        check_eq("t6_valid", 32'(bus.TableValid), 32'h8);
        check_eq("t6_error", 32'(bus.Error),      32'h0);
        check_eq("t6_busy",  32'(bus.Busy),       32'h0);
        rd("t6_idx63", 2'd3, 6'd63, 32'h006A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aq_djpeg_dqt_multi.md
# aq_djpeg_dqt_multi

Parametrised quantisation-table store for the JPEG decoder: parses the payload of a DQT marker segment byte by byte and writes up to NUM_TABLES tables of 64 entries each. Supports 8-bit (Pq=0) and 16-bit (Pq=1) precision and multiple tables per segment. It sits between the marker/header parser and the dequantiser, which reads entries through a one-cycle-latency lookup port.

## Interface
- NUM_TABLES, 4, number of table slots (1..4); Tq values at or above this are rejected
- OUT_W, 16, TableData width (8 or 16); 8-bit entries are zero-extended, 16-bit entries are truncated to the low OUT_W bits
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- DataInStart  in  1  one-cycle pulse before the first payload byte (after the length field)
- DataInEnable  in  1  DataIn valid this cycle; no backpressure
- DataIn  in  8  payload byte
- DataInLast  in  1  qualifies DataInEnable: final payload byte of the segment
- Busy  out  1  parser not in IDLE
- TableValid  out  NUM_TABLES  bit n set while table n holds a complete table
- Error  out  1  sticky segment error, cleared by DataInStart
- TableSel  in  clog2(NUM_TABLES) (min 1)  table to read
- TableNumber  in  6  entry index, in stream order (zig-zag order as stored)
- TableData  out  OUT_W  entry, registered

## Operation
- States: IDLE, HEADER, ENTRY_HI, ENTRY_LO, SKIP.
- IDLE: DataInStart -> HEADER and clear Error. Bytes arriving in IDLE are ignored.
- HEADER, on an enable byte: Pq=DataIn[7:4], Tq=DataIn[3:0].
  - If Pq>1 or Tq>=NUM_TABLES: set Error, go to SKIP, or to IDLE if DataInLast.
  - Otherwise clear TableValid[Tq], clear the entry counter, and go to ENTRY_HI if Pq=1, else ENTRY_LO.
  - DataInLast on a valid header: set Error, go to IDLE.
- ENTRY_HI (Pq=1 only): latch the high byte, go to ENTRY_LO.
- ENTRY_LO: write {hi,DataIn} (Pq=1) or {8'h00,DataIn} (Pq=0) to address {Tq,count} and increment count.
  - When count=63: set TableValid[Tq]. Next state is IDLE if DataInLast, else HEADER (next table in the same segment).
  - Otherwise next state is ENTRY_HI if Pq=1, else ENTRY_LO.
- DataInLast before entry 63 is written: set Error, go to IDLE. The table stays invalid; entries already written remain in RAM.
- SKIP: consume bytes until DataInLast, then go to IDLE.
- DataInStart in any state: abort, go to HEADER, clear Error. A partially loaded table stays invalid. DataInStart wins over an enable in the same cycle, and that byte is dropped.
- Reloading a valid table: its valid bit drops at header acceptance and rises again at completion.
- Read port is independent of the parser. A read and a write to the same address in the same cycle return the old data (read-first).

## Timing
- Reset values: Busy=0, TableValid=0, Error=0, TableData=0, state IDLE, counter 0. RAM contents are not reset.
- Reset mid-load: immediate return to IDLE with all valid bits cleared.
- Throughput is one byte per cycle. Back-to-back enables are legal in every state.
- Write occurs on the rising edge that samples the final byte of an entry. The entry is readable at the next edge.
- TableValid[Tq] rises one cycle after the edge that samples entry 63's last byte. TableValid[Tq] falls one cycle after the header byte.
- Error rises one cycle after the offending byte.
- Read latency: TableData reflects TableSel/TableNumber sampled at the previous edge.
- Busy is registered from the state: 1 from the cycle after DataInStart until the cycle after the byte that returns the parser to IDLE.

## Structure
- Shared package/include `aq_djpeg_defs`: DQT_ENTRIES=64, state encodings, PQ_8BIT/PQ_16BIT constants.
- Sub-module `aq_djpeg_dqt_ram`: simple dual-port RAM, depth NUM_TABLES*64, width OUT_W, synchronous write, registered read-first output with async reset on the output register.
- Top level holds the parser FSM, the counter, the Tq/Pq/high-byte registers and the valid/error flags.

## Test plan
- Pq=0, Tq=1, bytes 1..64 with DataInLast on 64 -> TableValid=4'b0010; read sel=1, idx=0 -> 16'h0001; idx=63 -> 16'h0040 one cycle after the address.
- Pq=1, Tq=0, entries 16'h0100+i, MSB first, 129 bytes -> TableValid[0]=1; idx=5 -> 16'h0105; Error=0.
- One segment with headers 8'h00 and 8'h03 (two 8-bit tables, 130 bytes) -> TableValid=4'b1001; Busy falls one cycle after the last byte.
- Header 8'h05 with NUM_TABLES=4 -> Error=1, remaining bytes skipped, TableValid unchanged; next DataInStart clears Error.
- Pq=0 table with DataInLast on byte 30 -> Error=1, TableValid bit clear; a mid-stream DataInStart followed by a full table recovers with Error=0.
- rst low during entry 40 -> outputs return to reset values immediately; a subsequent full load succeeds.
